// File: rtl/demux_1_4_stream_if.sv
// demux_1_4_stream_if: input beat channel plus four output lanes of the 1:4 stream demux.
interface demux_1_4_stream_if #(parameter int W = 4);
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   in_data;
    logic [1:0]     in_sel;
    logic [3:0]     out_valid;
    logic [3:0]     out_ready;
    logic [4*W-1:0] out_data;
    modport master (
        output in_valid, in_data, in_sel, out_ready,
        input  in_ready, out_valid, out_data
    );
    modport slave (
        input  in_valid, in_data, in_sel, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/demux_1_4_stream.sv
// demux_1_4_stream: routes each input beat by in_sel into one of four independent FIFOs.
module demux_1_4_stream #(
    parameter int W     = 4,
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst_n,
    demux_1_4_stream_if.slave s,
    output logic busy
);
    localparam int AW = $clog2(DEPTH);
    logic [3:0]     full;
    logic [3:0]     vld;
    logic [4*W-1:0] dat;
    for (genvar k = 0; k < 4; k++) begin : g_ch
        logic [W-1:0]  mem [DEPTH];
        logic [AW-1:0] wp, rp;
        logic [AW:0]   cnt;
        logic          push, pop;
        assign push = s.in_valid && !full[k] && s.in_sel == 2'(k);
        assign pop  = vld[k] && s.out_ready[k];
        assign full[k] = cnt == (AW+1)'(DEPTH);
        assign vld[k] = cnt != '0;
        assign dat[k*W +: W] = mem[rp];
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                wp  <= '0;
                rp  <= '0;
                cnt <= '0;
                for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            end else begin
                if (push) mem[wp] <= s.in_data;
                wp  <= wp + AW'(push);
                rp  <= rp + AW'(pop);
                cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
            end
        end
    end
    // Readiness looks only at the full flag, so a same-cycle pop never frees a slot.
    assign s.in_ready  = !full[s.in_sel];
    assign s.out_valid = vld;
    assign s.out_data  = dat;
    assign busy        = |vld;
endmodule

// File: tb/tb_demux_1_4_stream.sv
// tb_demux_1_4_stream: directed and random traffic against a per-channel queue scoreboard.
module tb_demux_1_4_stream;
    logic clk = 1'b0;
    logic rst_n;
    logic busy;
    int   pass_cnt = 0;
    int   total    = 0;
    logic [3:0] sb [4][$];
    demux_1_4_stream_if #(.W(4)) bus ();
    demux_1_4_stream #(.W(4), .DEPTH(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .s     (bus.slave),
        .busy  (busy)
    );
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One cycle: drive at negedge, check settled outputs, then advance the model for the next edge.
    task automatic step(input logic v, input logic [1:0] sel, input logic [3:0] d, input logic [3:0] rdy);
        logic [3:0] mv;
        logic       mr;
        @(negedge clk);
        bus.in_valid  = v;
        bus.in_sel    = sel;
        bus.in_data   = d;
        bus.out_ready = rdy;
        #1;
        for (int k = 0; k < 4; k++) mv[k] = sb[k].size() != 0;
        mr = sb[sel].size() < 2;
        chk("in_ready", 32'(bus.in_ready), 32'(mr));
        chk("out_valid", 32'(bus.out_valid), 32'(mv));
        chk("busy", 32'(busy), 32'(|mv));
        for (int k = 0; k < 4; k++)
            if (mv[k]) chk($sformatf("lane%0d", k), 32'(bus.out_data[k*4 +: 4]), 32'(sb[k][0]));
        for (int k = 0; k < 4; k++)
            if (mv[k] && rdy[k]) void'(sb[k].pop_front());
        if (v && mr) sb[sel].push_back(d);
    endtask

    task automatic drain();
        repeat (3) step(1'b0, 2'd0, 4'h0, 4'hF);
    endtask

    initial begin
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_sel = 2'd0;
        bus.in_data = 4'h0;
        bus.out_ready = 4'h0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_out_data", 32'(bus.out_data), 32'h0);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", 32'(bus.in_ready), 32'h1);
        // 1: single beat, one-cycle latency even with consumer ready
        step(1'b1, 2'd2, 4'hA, 4'hF);
        step(1'b0, 2'd0, 4'h0, 4'hF);
        step(1'b0, 2'd0, 4'h0, 4'hF);
        // 2: fill channel 1, third beat waits for a real pop
        step(1'b1, 2'd1, 4'h1, 4'h0);
        step(1'b1, 2'd1, 4'h2, 4'h0);
        step(1'b1, 2'd1, 4'h3, 4'h0);
        chk("ch1_full_refuse", 32'(bus.in_ready), 32'h0);
        step(1'b1, 2'd1, 4'h3, 4'h2);
        step(1'b1, 2'd1, 4'h3, 4'h2);
        drain();
        // 3: stalled channel 0 does not block channel 3
        step(1'b1, 2'd0, 4'h7, 4'h0);
        step(1'b1, 2'd0, 4'h8, 4'h0);
        step(1'b1, 2'd0, 4'h9, 4'h0);
        step(1'b1, 2'd3, 4'hB, 4'h8);
        step(1'b1, 2'd3, 4'hC, 4'h8);
        step(1'b1, 2'd3, 4'hD, 4'h8);
        step(1'b0, 2'd0, 4'h0, 4'h8);
        drain();
        // 4: random selects, all consumers ready
        for (int i = 0; i < 200; i++)
            step(1'b1, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 4'hF);
        drain();
        // 5: same-cycle push and pop on one-entry channel 2
        step(1'b1, 2'd2, 4'h5, 4'h0);
        step(1'b1, 2'd2, 4'h6, 4'h4);
        step(1'b0, 2'd0, 4'h0, 4'h0);
        chk("ch2_after_pushpop", 32'(bus.out_data[11:8]), 32'h6);
        chk("ch2_room", 32'(sb[2].size()), 32'h1);
        drain();
        // 6: asynchronous reset with three channels holding data
        step(1'b1, 2'd0, 4'h1, 4'h0);
        step(1'b1, 2'd1, 4'h2, 4'h0);
        step(1'b1, 2'd3, 4'h3, 4'h0);
        step(1'b0, 2'd0, 4'h0, 4'h0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_out_valid", 32'(bus.out_valid), 32'h0);
        chk("async_busy", 32'(busy), 32'h0);
        chk("async_out_data", 32'(bus.out_data), 32'h0);
        for (int k = 0; k < 4; k++) sb[k].delete();
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            bus.in_sel = 2'(k);
            #1;
            chk($sformatf("post_rst_ready%0d", k), 32'(bus.in_ready), 32'h1);
        end
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
